// File: rtl/idct_pkg.sv
// -----------------------------------------------------------------------------
// idct_pkg
// Shared definitions for the IDCT back end: default datapath widths, the
// tap count per output sample, the IDCT coefficient constants used by the
// multiply stage, and the round/shift/saturate helper that this accumulator
// and the later stages use to narrow wide sums into output samples.
// -----------------------------------------------------------------------------
package idct_pkg;

    // Default datapath geometry
    localparam int IDCT_TAPS   = 8;
    localparam int IDCT_PROD_W = 16;
    localparam int IDCT_ACC_W  = 19;
    localparam int IDCT_SHIFT  = 7;
    localparam int IDCT_OUT_W  = 10;

    // IDCT basis coefficients (scaled by 64)
    localparam logic signed [7:0] IDCT_C64 = 8'sd64;
    localparam logic signed [7:0] IDCT_C83 = 8'sd83;
    localparam logic signed [7:0] IDCT_C89 = 8'sd89;
    localparam logic signed [7:0] IDCT_C75 = 8'sd75;
    localparam logic signed [7:0] IDCT_C50 = 8'sd50;
    localparam logic signed [7:0] IDCT_C36 = 8'sd36;

    // Result of a round/shift/saturate step: clipped sample plus clip flag
    typedef struct packed {
        logic signed [IDCT_OUT_W-1:0] val;
        logic                         sat;
    } sat_res_t;

    // Round half-up, arithmetic right shift (floor for negatives), then clip
    // to the signed range of out_w_i bits. out_w_i must not exceed IDCT_OUT_W.
    function automatic sat_res_t sat_round(input logic signed [31:0] sum_i,
                                           input int                 shift_i,
                                           input int                 out_w_i);
        sat_res_t           res;
        logic signed [31:0] rnd;
        logic signed [31:0] max_v;
        logic signed [31:0] min_v;
        rnd   = (sum_i + (32'sd1 <<< (shift_i - 1))) >>> shift_i;
        max_v = (32'sd1 <<< (out_w_i - 1)) - 32'sd1;
        min_v = -max_v - 32'sd1;
        if (rnd > max_v) begin
            res.val = max_v[IDCT_OUT_W-1:0];
            res.sat = 1'b1;
        end else if (rnd < min_v) begin
            res.val = min_v[IDCT_OUT_W-1:0];
            res.sat = 1'b1;
        end else begin
            res.val = rnd[IDCT_OUT_W-1:0];
            res.sat = 1'b0;
        end
        return res;
    endfunction

endpackage

// File: rtl/idct_out_fifo.sv
// -----------------------------------------------------------------------------
// idct_out_fifo
// Two-entry synchronous FIFO built as a shift pair (head/tail) so the head
// entry is always a flop and drives the consumer directly.
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   push_i         write push_data_i (ignored when full without a pop)
//   push_data_i    entry to write
//   pop_i          drop the head entry (ignored when empty)
//   head_data_o    current head entry (zero after reset)
//   count_o        number of valid entries, 0..2
// -----------------------------------------------------------------------------
module idct_out_fifo #(
    parameter int W = 11
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push_i,
    input  logic [W-1:0] push_data_i,
    input  logic         pop_i,
    output logic [W-1:0] head_data_o,
    output logic [1:0]   count_o
);

    logic [W-1:0] head_q, head_d;
    logic [W-1:0] tail_q, tail_d;
    logic [1:0]   count_q, count_d;
    logic         push_s;
    logic         pop_s;

    assign pop_s  = pop_i && (count_q != 2'd0);
    // A full FIFO only takes a push when the head leaves in the same cycle
    assign push_s = push_i && ((count_q != 2'd2) || pop_s);

    // Next-state for head/tail slots and occupancy
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        case ({push_s, pop_s})
            2'b10: begin
                if (count_q == 2'd0) begin
                    head_d = push_data_i;
                end else begin
                    tail_d = push_data_i;
                end
                count_d = count_q + 2'd1;
            end
            2'b01: begin
                head_d  = tail_q;
                count_d = count_q - 2'd1;
            end
            2'b11: begin
                if (count_q == 2'd1) begin
                    head_d = push_data_i;
                end else begin
                    head_d = tail_q;
                    tail_d = push_data_i;
                end
            end
            default: begin
                count_d = count_q;
            end
        endcase
    end

    // FIFO storage and occupancy registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q  <= {W{1'b0}};
            tail_q  <= {W{1'b0}};
            count_q <= 2'd0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    assign head_data_o = head_q;
    assign count_o     = count_q;

endmodule

// File: rtl/idct_tap_accum.sv
// -----------------------------------------------------------------------------
// idct_tap_accum
// Sums each group of TAPS signed products from the IDCT multiply stage, then
// rounds, shifts and saturates the sum into one output sample. Samples are
// buffered in a 2-entry FIFO with valid/ready handshakes on both sides.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid/in_ready   product handshake
//   in_data             signed product
//   in_last             marks final product of a group
//   out_valid/out_ready sample handshake (FIFO head)
//   out_data, out_sat   rounded/saturated sample and its clip flag
//   frame_err           one-cycle pulse when in_last disagrees with the tap count
// -----------------------------------------------------------------------------
module idct_tap_accum
    import idct_pkg::*;
#(
    parameter int PROD_W = IDCT_PROD_W,
    parameter int TAPS   = IDCT_TAPS,
    parameter int ACC_W  = IDCT_ACC_W,
    parameter int SHIFT  = IDCT_SHIFT,
    parameter int OUT_W  = IDCT_OUT_W
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [PROD_W-1:0] in_data,
    input  logic                     in_last,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [OUT_W-1:0]  out_data,
    output logic                     out_sat,
    output logic                     frame_err
);

    localparam int               CNT_W    = $clog2(TAPS);
    localparam logic [CNT_W-1:0] LAST_TAP = CNT_W'(TAPS - 1);
    localparam logic [CNT_W-1:0] TAP_ZERO = {CNT_W{1'b0}};

    logic [CNT_W-1:0]        tap_cnt_q, tap_cnt_d;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic                    frame_err_q, frame_err_d;

    logic signed [ACC_W-1:0] prod_ext_s;
    logic signed [ACC_W-1:0] sum_s;
    logic                    accept_s;
    logic                    at_last_s;
    logic                    push_s;
    logic                    pop_s;
    logic [1:0]              fifo_count_s;
    sat_res_t                res_s;
    logic [OUT_W:0]          push_data_s;
    logic [OUT_W:0]          head_data_s;

    assign prod_ext_s = {{(ACC_W - PROD_W){in_data[PROD_W-1]}}, in_data};
    assign at_last_s  = (tap_cnt_q == LAST_TAP);
    // Only the final tap needs FIFO room; depends on registered state only
    assign in_ready   = at_last_s ? (fifo_count_s < 2'd2) : 1'b1;
    assign accept_s   = in_valid && in_ready;
    assign sum_s      = acc_q + prod_ext_s;

    // Narrow the completed group sum into an output sample
    always_comb begin
        res_s       = sat_round(32'(sum_s), SHIFT, OUT_W);
        push_data_s = {OUT_W'(res_s.val), res_s.sat};
    end

    // Tap counter, accumulator and in_last alignment check
    always_comb begin
        tap_cnt_d   = tap_cnt_q;
        acc_d       = acc_q;
        frame_err_d = 1'b0;
        push_s      = 1'b0;
        if (accept_s) begin
            if (at_last_s) begin
                // Group complete: push even if in_last was missing
                tap_cnt_d   = TAP_ZERO;
                acc_d       = sum_s;
                push_s      = 1'b1;
                frame_err_d = !in_last;
            end else if (in_last) begin
                // Early in_last: drop the partial group and realign
                tap_cnt_d   = TAP_ZERO;
                acc_d       = {ACC_W{1'b0}};
                frame_err_d = 1'b1;
            end else begin
                tap_cnt_d = tap_cnt_q + CNT_W'(1);
                acc_d     = (tap_cnt_q == TAP_ZERO) ? prod_ext_s : sum_s;
            end
        end else begin
            tap_cnt_d = tap_cnt_q;
        end
    end

    // Accumulator-side state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tap_cnt_q   <= TAP_ZERO;
            acc_q       <= {ACC_W{1'b0}};
            frame_err_q <= 1'b0;
        end else begin
            tap_cnt_q   <= tap_cnt_d;
            acc_q       <= acc_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign pop_s = out_valid && out_ready;

    idct_out_fifo #(
        .W (OUT_W + 1)
    ) u_out_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_i      (push_s),
        .push_data_i (push_data_s),
        .pop_i       (pop_s),
        .head_data_o (head_data_s),
        .count_o     (fifo_count_s)
    );

    assign out_valid = (fifo_count_s != 2'd0);
    assign out_data  = head_data_s[OUT_W:1];
    assign out_sat   = head_data_s[0];
    assign frame_err = frame_err_q;

endmodule

// File: tb/tb_idct_tap_accum.sv
// -----------------------------------------------------------------------------
// tb_idct_tap_accum
// Directed self-checking bench for idct_tap_accum with hand-computed
// expected sample values.
// -----------------------------------------------------------------------------
module tb_idct_tap_accum;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               in_valid;
    logic               in_ready;
    logic signed [15:0] in_data;
    logic               in_last;
    logic               out_valid;
    logic               out_ready;
    logic signed [9:0]  out_data;
    logic               out_sat;
    logic               frame_err;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    idct_tap_accum dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_sat   (out_sat),
        .frame_err (frame_err)
    );

    task automatic chk(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Present one product and hold it until accepted (bounded wait)
    task automatic drive(input logic signed [15:0] d, input logic l);
        int n;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        n = 0;
        while (!in_ready && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("accept_wait", {31'd0, in_ready}, 32'sd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic send_group(input logic signed [15:0] d, input int n,
                              input logic last_on_end);
        for (int i = 0; i < n; i++) begin
            drive(d, last_on_end && (i == n - 1));
        end
    endtask

    // Pop the head entry, checking it first
    task automatic pop_one(input string tag, input int exp_d, input int exp_s);
        out_ready = 1'b1;
        chk({tag, "_valid"}, {31'd0, out_valid}, 32'sd1);
        chk({tag, "_data"}, out_data, exp_d);
        chk({tag, "_sat"}, {31'd0, out_sat}, exp_s);
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 16'sd0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", {31'd0, out_valid}, 32'sd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'sd1);
        chk("rst_out_data", out_data, 32'sd0);
        chk("rst_out_sat", {31'd0, out_sat}, 32'sd0);
        chk("rst_frame_err", {31'd0, frame_err}, 32'sd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Positive group: 8*192 = 1536, (1536+64)>>7 = 12
        send_group(16'sd192, 8, 1'b1);
        chk("pos_latency_valid", {31'd0, out_valid}, 32'sd1);
        chk("pos_frame_err", {31'd0, frame_err}, 32'sd0);
        pop_one("pos", 12, 0);
        chk("pos_drained", {31'd0, out_valid}, 32'sd0);

        // Negative group: (-1536+64)>>>7 = -12
        send_group(-16'sd192, 8, 1'b1);
        pop_one("neg", -12, 0);

        // Saturation both ways
        send_group(16'sd32767, 8, 1'b1);
        pop_one("sat_hi", 511, 1);
        send_group(-16'sd32768, 8, 1'b1);
        pop_one("sat_lo", -512, 1);

        // Backpressure: groups 12, -12, 5 (8*80=640 -> (640+64)>>7 = 5)
        send_group(16'sd192, 8, 1'b1);
        send_group(-16'sd192, 8, 1'b1);
        send_group(16'sd80, 7, 1'b0);
        chk("bp_fifo_full", {31'd0, out_valid}, 32'sd1);
        in_valid = 1'b1;
        in_data  = 16'sd80;
        in_last  = 1'b1;
        chk("bp_stall_last", {31'd0, in_ready}, 32'sd0);
        @(posedge clk);
        #1;
        chk("bp_stall_hold", {31'd0, in_ready}, 32'sd0);
        chk("bp_head_stable", out_data, 32'sd12);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        // 12 popped; room for the stalled last product now
        chk("bp_ready_after_pop", {31'd0, in_ready}, 32'sd1);
        chk("bp_second", out_data, -32'sd12);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        chk("bp_third_valid", {31'd0, out_valid}, 32'sd1);
        chk("bp_third", out_data, 32'sd5);
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("bp_empty", {31'd0, out_valid}, 32'sd0);

        // Early in_last at the 4th product
        send_group(16'sd192, 4, 1'b1);
        chk("early_frame_err", {31'd0, frame_err}, 32'sd1);
        chk("early_no_output", {31'd0, out_valid}, 32'sd0);
        @(posedge clk);
        #1;
        chk("early_pulse_width", {31'd0, frame_err}, 32'sd0);
        send_group(-16'sd192, 8, 1'b1);
        chk("realign_frame_err", {31'd0, frame_err}, 32'sd0);
        pop_one("realign", -12, 0);

        // Missing in_last: result still pushed, error pulses
        send_group(16'sd80, 8, 1'b0);
        chk("missing_frame_err", {31'd0, frame_err}, 32'sd1);
        pop_one("missing", 5, 0);
        chk("missing_pulse_width", {31'd0, frame_err}, 32'sd0);

        // Reset with one result buffered and a partial group in flight
        send_group(16'sd192, 8, 1'b1);
        send_group(16'sd80, 5, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", {31'd0, out_valid}, 32'sd0);
        chk("mid_rst_in_ready", {31'd0, in_ready}, 32'sd1);
        chk("mid_rst_out_data", out_data, 32'sd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("post_rst_out_valid", {31'd0, out_valid}, 32'sd0);
        send_group(-16'sd192, 8, 1'b1);
        pop_one("post_rst", -12, 0);
        chk("post_rst_single", {31'd0, out_valid}, 32'sd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
